fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 8: instruction entries; power of two, at least 4.
REQ-002 Parameter IN_W, default 2: instructions offered per push, 1..4.
REQ-003 Parameter OUT_W, default 2: instructions presented per cycle, 1..4.
REQ-004 Parameter META_W, default 42: per-packet sideband width (cookie, exception, excp_flag, ibar, cacop bits).
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rstn  in  1  reset, synchronous, active-low.
REQ-007 flush  in  1  discard all queued contents.
REQ-008 in_valid  in  1  push request.
REQ-009 in_ready  out  1  queue can accept a full IN_W packet.
REQ-010 in_mask  in  IN_W  per-slot instruction valid; slot 0 is lowest.
REQ-011 in_inst  in  IN_W*32  instructions; slot i is bits [32i+31:32i].
REQ-012 in_pc  in  32  PC of slot 0; PC of slot i is in_pc+4i.
REQ-013 in_meta  in  META_W  sideband; copied to every instruction of the packet.
REQ-014 out_valid  out  OUT_W  thermometer code; bit i set iff count>i.
REQ-015 out_inst / out_pc / out_meta  out  OUT_W*32 / OUT_W*32 / OUT_W*META_W  head-order entries.
REQ-016 pop_cnt  in  $clog2(OUT_W+1)  number of head entries consumed this cycle.
REQ-017 count  out  $clog2(DEPTH+1)  occupied entries.
REQ-018 empty / full  out  1 / 1  empty is count==0; full is count==DEPTH.

Function
REQ-019 in_ready SHALL be (DEPTH-count)>=IN_W, computed from current count only; it does not credit a same-cycle pop.
REQ-020 A push SHALL occur iff in_valid && in_ready && !flush.
REQ-021 On a push, masked-in slots SHALL be compacted in ascending slot order and written contiguously from tail; holes in in_mask consume no entry.
REQ-022 A push with in_mask==0 SHALL change no state.
REQ-023 Output entry i SHALL be the storage at (head+i) mod DEPTH, driven combinationally from storage; push-to-out_valid latency is 1 cycle, with no same-cycle bypass.
REQ-024 head SHALL advance by pop_cnt; tail SHALL advance by popcount(in_mask) on a push; both pointers wrap mod DEPTH.
REQ-025 count_next SHALL be count + pushed - popped; simultaneous push and pop in one cycle is legal.
REQ-026 pop_cnt greater than the number of set out_valid bits is illegal; the design SHALL clamp it to that number, and a simulation-only assertion SHALL fire.
REQ-027 Flush SHALL take priority over push and pop: next cycle count=0, head=tail=0, and the push is dropped.
REQ-028 Invalid output slots SHALL drive out_inst=`INST_NOP, out_pc=`PC_RESET and out_meta=0.
REQ-029 Storage arrays SHALL have no reset; only pointers and count are reset.

Reset
REQ-030 With rstn low at a clock edge, next cycle: head=tail=count=0, empty=1, full=0, in_ready=1, out_valid=0, invalid-slot values per REQ-028.
REQ-031 Reset SHALL override flush, push and pop in the same cycle; entries in flight are lost.

Structure
REQ-032 `INST_NOP and `PC_RESET SHALL come from the shared define.vh; no new global constants are introduced.
REQ-033 One sub-module, fq_pack, SHALL hold the combinational compaction of IN_W masked slots into contiguous lanes plus the lane count.
REQ-034 Packed storage SHALL be a single array of width 32+32+META_W.

Verification
REQ-035 Defaults; push mask=11, inst={B,A}, pc=0x1c000000 -> next cycle count=2, out_valid=11, out_pc={0x1c000004,0x1c000000}.
REQ-036 Push mask=10, pc=0x1c000010 into an empty queue -> count=1, out_inst[0]=slot1 instruction, out_pc[0]=0x1c000014.
REQ-037 Fill to count=7 -> in_ready=0; at count=6, push 11 with pop_cnt=1 -> count=7.
REQ-038 Run 20 cycles of push 11 / pop_cnt=2 -> pointers wrap, count stays 2, and the PC sequence is monotonic by 4 with no gaps.
REQ-039 At count=5, flush=1 together with in_valid=1 -> next cycle count=0, out_valid=00, and the pushed packet is absent.
REQ-040 Assert rstn=0 at count=4 -> next cycle count=0 and out_pc[0]=`PC_RESET; with DEPTH=16, IN_W=4, OUT_W=1, push mask=0101 -> count=2.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared widths for the fetch queue slice.
package fetch_queue_pkg;
  localparam int INST_W = 32;
  localparam int PC_W   = 32;
  localparam int PC_STEP = 4;
endpackage

// File: rtl/define.vh
`ifndef DEFINE_VH
`define DEFINE_VH
`define INST_NOP 32'h03400000
`define PC_RESET 32'h1c000000
`endif

// File: rtl/fq_pack.sv
// Compacts masked-in fetch slots into contiguous lanes with their PCs; purely combinational.
module fq_pack
  import fetch_queue_pkg::*;
#(
  parameter int IN_W   = 2,
  parameter int LANE_W = $clog2(IN_W + 1)
) (
  input  logic [IN_W-1:0]        mask,
  input  logic [IN_W*INST_W-1:0] inst,
  input  logic [PC_W-1:0]        pc,
  output logic [IN_W*INST_W-1:0] lane_inst,
  output logic [IN_W*PC_W-1:0]   lane_pc,
  output logic [LANE_W-1:0]      lane_cnt
);

  always_comb begin
    int k;
    k         = 0;
    lane_inst = '0;
    lane_pc   = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (mask[i]) begin
        lane_inst[k*INST_W +: INST_W] = inst[i*INST_W +: INST_W];
        lane_pc[k*PC_W +: PC_W]       = pc + PC_W'(PC_STEP * i);
        k = k + 1;
      end
    end
    lane_cnt = LANE_W'(k);
  end

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction queue: compacted pushes from tail, up to OUT_W head entries shown; 1-cycle push-to-valid.
// in_ready needs room for a full IN_W packet from the current count; over-pops are clamped.
`include "define.vh"
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int IN_W   = 2,
  parameter int OUT_W  = 2,
  parameter int META_W = 42
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_W-1:0]               in_mask,
  input  logic [IN_W*INST_W-1:0]        in_inst,
  input  logic [PC_W-1:0]               in_pc,
  input  logic [META_W-1:0]             in_meta,
  output logic [OUT_W-1:0]              out_valid,
  output logic [OUT_W*INST_W-1:0]       out_inst,
  output logic [OUT_W*PC_W-1:0]         out_pc,
  output logic [OUT_W*META_W-1:0]       out_meta,
  input  logic [$clog2(OUT_W+1)-1:0]    pop_cnt,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          empty,
  output logic                          full
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int POP_W  = $clog2(OUT_W + 1);
  localparam int LANE_W = $clog2(IN_W + 1);
  localparam int ENT_W  = PC_W + INST_W + META_W;

  logic [ENT_W-1:0]       mem [DEPTH];
  logic [PTR_W-1:0]       head;
  logic [PTR_W-1:0]       tail;
  logic [IN_W*INST_W-1:0] lane_inst;
  logic [IN_W*PC_W-1:0]   lane_pc;
  logic [LANE_W-1:0]      lane_cnt;
  logic [LANE_W-1:0]      push_n;
  logic [POP_W-1:0]       avail;
  logic [POP_W-1:0]       pop_n;
  logic                   push;

  fq_pack #(.IN_W(IN_W), .LANE_W(LANE_W)) u_pack (
    .mask      (in_mask),
    .inst      (in_inst),
    .pc        (in_pc),
    .lane_inst (lane_inst),
    .lane_pc   (lane_pc),
    .lane_cnt  (lane_cnt)
  );

  assign in_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(IN_W);
  assign push     = in_valid && in_ready && !flush;
  assign push_n   = push ? lane_cnt : '0;
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));

  // Consumers may only take what is shown; anything more is trimmed here.
  assign avail = (count >= CNT_W'(OUT_W)) ? POP_W'(OUT_W) : POP_W'(count);
  assign pop_n = (pop_cnt > avail) ? avail : pop_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_n);
      tail  <= tail + PTR_W'(push_n);
      count <= count + CNT_W'(push_n) - CNT_W'(pop_n);
    end
  end

  // Storage carries no reset; only entries covered by count are ever observed.
  always_ff @(posedge clk) begin
    if (rstn && push) begin
      for (int i = 0; i < IN_W; i++) begin
        if (i < int'(lane_cnt))
          mem[tail + PTR_W'(i)] <= {lane_pc[i*PC_W +: PC_W], lane_inst[i*INST_W +: INST_W], in_meta};
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    out_pc    = '0;
    out_meta  = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (count > CNT_W'(i)) begin
        out_valid[i]                = 1'b1;
        out_pc[i*PC_W +: PC_W]       = mem[head + PTR_W'(i)][ENT_W-1 -: PC_W];
        out_inst[i*INST_W +: INST_W] = mem[head + PTR_W'(i)][META_W +: INST_W];
        out_meta[i*META_W +: META_W] = mem[head + PTR_W'(i)][META_W-1:0];
      end else begin
        out_pc[i*PC_W +: PC_W]       = `PC_RESET;
        out_inst[i*INST_W +: INST_W] = `INST_NOP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && !flush)
      assert (pop_cnt <= avail);
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboarded bench: stimulus queues expected entries, a negedge monitor checks every popped head entry.
module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'h03400000;
  localparam logic [31:0] PCR = 32'h1c000000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [41:0] meta;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, flush, in_valid, in_ready, empty, full;
  logic [1:0]  in_mask, out_valid, pop_cnt;
  logic [63:0] in_inst, out_inst, out_pc;
  logic [31:0] in_pc;
  logic [41:0] in_meta;
  logic [83:0] out_meta;
  logic [3:0]  count;

  logic         b_flush, b_in_valid, b_in_ready, b_empty, b_full;
  logic [3:0]   b_in_mask;
  logic [127:0] b_in_inst;
  logic [31:0]  b_in_pc, b_out_inst, b_out_pc;
  logic [41:0]  b_in_meta, b_out_meta;
  logic [0:0]   b_out_valid, b_pop_cnt;
  logic [4:0]   b_count;

  fetch_queue dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_mask(in_mask), .in_inst(in_inst), .in_pc(in_pc), .in_meta(in_meta),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_meta(out_meta),
    .pop_cnt(pop_cnt), .count(count), .empty(empty), .full(full)
  );

  fetch_queue #(.DEPTH(16), .IN_W(4), .OUT_W(1), .META_W(42)) dut_b (
    .clk(clk), .rstn(rstn), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_mask(b_in_mask), .in_inst(b_in_inst), .in_pc(b_in_pc), .in_meta(b_in_meta),
    .out_valid(b_out_valid), .out_inst(b_out_inst), .out_pc(b_out_pc), .out_meta(b_out_meta),
    .pop_cnt(b_pop_cnt), .count(b_count), .empty(b_empty), .full(b_full)
  );

  ent_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_cnt = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [41:0] meta_of(input logic [31:0] pc);
    return {10'h2A5, pc};
  endfunction

  task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] pc,
                       input logic [1:0] pop, input logic fl);
    in_valid = v;
    in_mask  = m;
    in_pc    = pc;
    in_inst  = {ins_of(pc + 32'd4), ins_of(pc)};
    in_meta  = meta_of(pc);
    pop_cnt  = pop;
    flush    = fl;
    if (!rstn || fl) begin
      exp_q.delete();
      m_cnt = 0;
    end else begin
      if (v && (8 - m_cnt) >= 2) begin
        for (int i = 0; i < 2; i++) begin
          if (m[i]) begin
            exp_q.push_back('{32'(pc + 32'(4 * i)), ins_of(32'(pc + 32'(4 * i))), meta_of(pc)});
            m_cnt++;
          end
        end
      end
      m_cnt -= int'(pop);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    ent_t e;
    if (rstn === 1'b1 && flush === 1'b0) begin
      for (int i = 0; i < int'(pop_cnt); i++) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL pop_underflow: slot %0d popped with scoreboard empty", i);
        end else begin
          e = exp_q.pop_front();
          check("pop_valid", 128'(out_valid[i]), 128'(1));
          check("pop_pc", 128'(out_pc[i*32 +: 32]), 128'(e.pc));
          check("pop_inst", 128'(out_inst[i*32 +: 32]), 128'(e.inst));
          check("pop_meta", 128'(out_meta[i*42 +: 42]), 128'(e.meta));
        end
      end
    end
  end

  initial begin
    logic [31:0] pc;
    rstn = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_mask = '0; b_in_inst = '0;
    b_in_pc = '0; b_in_meta = '0; b_pop_cnt = '0;
    drive(1'b0, 2'b00, 32'h0, 2'd0, 1'b0);
    tick();
    tick();
    check("rst_count", 128'(count), 128'(0));
    check("rst_empty", 128'(empty), 128'(1));
    check("rst_full", 128'(full), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_pc", 128'(out_pc), 128'({PCR, PCR}));
    check("rst_out_inst", 128'(out_inst), 128'({NOP, NOP}));
    check("rst_out_meta", 128'(out_meta), 128'(0));
    rstn = 1'b1;

    // Basic two-wide push, no same-cycle bypass
    drive(1'b1, 2'b11, 32'h1c000000, 2'd0, 1'b0);
    #1 check("no_bypass", 128'(out_valid), 128'(0));
    tick();
    check("push11_count", 128'(count), 128'(2));
    check("push11_valid", 128'(out_valid), 128'(2'b11));
    check("push11_pc", 128'(out_pc), 128'({32'h1c000004, 32'h1c000000}));
    drive(1'b0, 2'b00, 32'h0, 2'd2, 1'b0);
    tick();
    check("drain1_empty", 128'(empty), 128'(1));

    // Hole in the mask: slot 1 lands at the head
    drive(1'b1, 2'b10, 32'h1c000010, 2'd0, 1'b0);
    tick();
    check("mask10_count", 128'(count), 128'(1));
    check("mask10_valid", 128'(out_valid), 128'(2'b01));
    check("mask10_inst", 128'(out_inst[31:0]), 128'(ins_of(32'h1c000014)));
    check("mask10_pc", 128'(out_pc[31:0]), 128'(32'h1c000014));
    drive(1'b0, 2'b00, 32'h0, 2'd1, 1'b0);
    tick();
    check("mask10_drain", 128'(count), 128'(0));

    // Fill behaviour and in_ready
    pc = 32'h1c001000;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'b11, pc, 2'd0, 1'b0); pc += 32'd8; tick();
    end
    check("fill6_count", 128'(count), 128'(6));
    check("fill6_ready", 128'(in_ready), 128'(1));
    drive(1'b1, 2'b11, pc, 2'd1, 1'b0); pc += 32'd8; tick();
    check("fill7_count", 128'(count), 128'(7));
    check("fill7_ready", 128'(in_ready), 128'(0));
    check("fill7_full", 128'(full), 128'(0));
    drive(1'b1, 2'b11, pc, 2'd0, 1'b0); pc += 32'd8; tick();
    check("fill7_dropped", 128'(count), 128'(7));
    drive(1'b0, 2'b00, 32'h0, 2'd1, 1'b0); tick();
    drive(1'b1, 2'b11, pc, 2'd0, 1'b0); pc += 32'd8; tick();
    check("full_count", 128'(count), 128'(8));
    check("full_flag", 128'(full), 128'(1));
    check("full_ready", 128'(in_ready), 128'(0));
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'b00, 32'h0, 2'd2, 1'b0); tick();
    end
    check("fill_drain", 128'(empty), 128'(1));

    // Steady-state streaming across pointer wrap
    pc = 32'h1c002000;
    drive(1'b1, 2'b11, pc, 2'd0, 1'b0); tick();
    for (int k = 0; k < 20; k++) begin
      pc += 32'd8;
      drive(1'b1, 2'b11, pc, 2'd2, 1'b0);
      check("stream_head_pc", 128'(out_pc[31:0]), 128'(pc - 32'd8));
      tick();
      check("stream_count", 128'(count), 128'(2));
    end
    drive(1'b0, 2'b00, 32'h0, 2'd2, 1'b0); tick();
    check("stream_drain", 128'(empty), 128'(1));

    // Flush beats a simultaneous push
    pc = 32'h1c003000;
    drive(1'b1, 2'b11, pc, 2'd0, 1'b0); tick();
    pc += 32'd8; drive(1'b1, 2'b11, pc, 2'd0, 1'b0); tick();
    pc += 32'd8; drive(1'b1, 2'b01, pc, 2'd0, 1'b0); tick();
    check("preflush_count", 128'(count), 128'(5));
    pc += 32'd8; drive(1'b1, 2'b11, pc, 2'd0, 1'b1); tick();
    check("flush_count", 128'(count), 128'(0));
    check("flush_valid", 128'(out_valid), 128'(0));
    pc += 32'd8; drive(1'b1, 2'b11, pc, 2'd0, 1'b0); tick();
    check("postflush_head", 128'(out_pc[31:0]), 128'(pc));
    check("postflush_count", 128'(count), 128'(2));
    drive(1'b0, 2'b00, 32'h0, 2'd2, 1'b0); tick();

    // Reset overrides push and pop
    pc = 32'h1c004000;
    drive(1'b1, 2'b11, pc, 2'd0, 1'b0); tick();
    pc += 32'd8; drive(1'b1, 2'b11, pc, 2'd0, 1'b0); tick();
    check("prerst_count", 128'(count), 128'(4));
    rstn = 1'b0;
    pc += 32'd8; drive(1'b1, 2'b11, pc, 2'd1, 1'b0); tick();
    check("midrst_count", 128'(count), 128'(0));
    check("midrst_pc", 128'(out_pc[31:0]), 128'(PCR));
    check("midrst_ready", 128'(in_ready), 128'(1));
    rstn = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 2'd0, 1'b0); tick();

    // Wide-in / narrow-out configuration with a sparse mask
    b_in_valid = 1'b1;
    b_in_mask  = 4'b0101;
    b_in_inst  = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    b_in_pc    = 32'h1c005000;
    b_in_meta  = 42'h12345;
    tick();
    b_in_valid = 1'b0;
    check("b_count", 128'(b_count), 128'(2));
    check("b_valid", 128'(b_out_valid), 128'(1));
    check("b_inst0", 128'(b_out_inst), 128'(32'hAAAA0000));
    check("b_pc0", 128'(b_out_pc), 128'(32'h1c005000));
    b_pop_cnt = 1'b1;
    tick();
    check("b_count_pop", 128'(b_count), 128'(1));
    check("b_inst1", 128'(b_out_inst), 128'(32'hCCCC0002));
    check("b_pc1", 128'(b_out_pc), 128'(32'h1c005008));
    check("b_meta1", 128'(b_out_meta), 128'(42'h12345));
    tick();
    b_pop_cnt = 1'b0;
    check("b_empty", 128'(b_empty), 128'(1));
    check("b_empty_pc", 128'(b_out_pc), 128'(PCR));

    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
